// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among N_REQ requesters.
// One operation is in flight at a time; the result returns on a per-requester valid/ready handshake.
module alu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ALU_LATENCY = 1,
    parameter int OP_W        = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][OP_W+63:0]    req_inst,
    output logic [N_REQ-1:0]               req_ready,
    output logic [OP_W+63:0]               alu_iw,
    input  logic [31:0]                    alu_result,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [31:0]                    rsp_result,
    input  logic [N_REQ-1:0]               rsp_ready,
    output logic                           busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);
    localparam int IW_W  = OP_W + 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW_W-1:0]  alu_iw_q, alu_iw_d;
    logic [31:0]      rsp_result_q, rsp_result_d;

    logic             found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   scan_sum;
    logic [PTR_W-1:0] scan_idx;

    // Scan upward from ptr, wrapping modulo N_REQ; the first valid index wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        alu_iw_d     = alu_iw_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    alu_iw_d = req_inst[grant_idx];
                    gnt_d    = grant_idx;
                    cnt_d    = CNT_W'(ALU_LATENCY);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_d = alu_result;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Acceptance is suppressed while reset is high so no requester believes it was served.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && found && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            alu_iw_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            alu_iw_q     <= alu_iw_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign alu_iw     = alu_iw_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one registered ALU (the `instruction_t` datapath: opcode, a, b → 32-bit result) between `N_REQ` requesters. Each requester presents an instruction with a valid/ready handshake. A round-robin arbiter issues one instruction at a time to the ALU, waits out the ALU latency, and returns the result to the winning requester with a second valid/ready handshake. The block sits between the requester ports and the single ALU instance; only one operation is in flight at a time.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `ALU_LATENCY`, 1: clock edges from `IW` change to the new `result` on the ALU output, 1..8.

- `clock`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `req_valid`  in  N_REQ: requester i holds a valid instruction.
- `req_inst`  in  N_REQ x instruction_t: per-requester instruction (opcode, a[31:0], b[31:0]).
- `req_ready`  out  N_REQ: one-hot acceptance, combinational, asserted only in IDLE.
- `alu_iw`  out  instruction_t: registered instruction driven to the ALU `IW` port.
- `alu_result`  in  32: ALU `result`.
- `rsp_valid`  out  N_REQ: one-hot, result available for requester i.
- `rsp_result`  out  32: registered result, shared by all requesters.
- `rsp_ready`  in  N_REQ: requester i accepts the result.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - Grant `g` is the first index with `req_valid` set, searching upward from `ptr` and wrapping modulo `N_REQ`.
  - `req_ready[g]`=1 in the same cycle. All other `req_ready` bits are 0.
  - With no valid request, `req_ready`=0 and the FSM stays in IDLE.
  - At the edge: `alu_iw`←`req_inst[g]`, `gnt`←g, `cnt`←`ALU_LATENCY`, state→WAIT.
- **WAIT**
  - If `cnt`≠0: `cnt`←`cnt`−1.
  - If `cnt`=0: `rsp_result`←`alu_result`, state→RESP.
  - `req_ready`=0 throughout WAIT.
- **RESP**
  - `rsp_valid[gnt]`=1.
  - On an edge with `rsp_ready[gnt]`=1: state→IDLE, `ptr`←(`gnt`+1) mod `N_REQ`.
  - Otherwise hold `rsp_valid` and `rsp_result` unchanged, with no limit on how long.
- **Hold rules**
  - `alu_iw` holds the last issued instruction between operations; it is never cleared except by reset.
  - `rsp_result` changes only on the WAIT→RESP edge.
  - `req_inst` is sampled only at the accept edge. Later changes, or `req_valid` dropping, do not affect the in-flight operation.
- **Ignored inputs**
  - `req_valid` from any requester, including `gnt` re-requesting, is ignored outside IDLE.
  - `rsp_ready` is ignored outside RESP.
- Requesters see no arithmetic in this block. Results are exactly the ALU's 32-bit output; overflow and wrap belong to the ALU.
- **Reset**
  - Takes effect at the next edge from any state, including mid-WAIT or mid-RESP.
  - After reset: state=IDLE, `ptr`=0, `cnt`=0, `alu_iw`=all zeros, `rsp_result`=0, `rsp_valid`=0, `busy`=0.
  - An in-flight operation is dropped and never responded to.
  - `req_ready` is 0 during any cycle in which `reset`=1.

## Timing
- Cycle numbering: cycle 0 is the accept cycle (`req_valid[g]`&`req_ready[g]`).
- Cycle 1: `alu_iw` shows the new instruction, `busy`=1.
- Cycles 1..`ALU_LATENCY`+1: WAIT. `rsp_result` is captured at the end of cycle `ALU_LATENCY`+1.
- Cycle `ALU_LATENCY`+2: first cycle with `rsp_valid[g]`=1.
- With `rsp_ready` already high, IDLE returns in cycle `ALU_LATENCY`+3. That is also the next accept cycle.
- Minimum issue period is `ALU_LATENCY`+3 cycles (4 with the default).
- Each stall cycle of `rsp_ready` adds one cycle to the period.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ−1,0. No requester waits more than N_REQ−1 other operations.

## Test plan
- **Single ADD, defaults:** after reset, `req_valid[0]`=1, opcode ADD, a=10, b=15, `rsp_ready`=all 1.
  - Expect `req_ready[0]`=1 in cycle 0.
  - Expect `alu_iw`.opcode=ADD in cycle 1.
  - Expect `rsp_valid`=4'b0001 and `rsp_result`=25 in cycle 3.
  - Expect `busy`=0 in cycle 4.
- **SUB on requester 2:** a=20, b=5.
  - Expect `rsp_valid`=4'b0100 and `rsp_result`=15 in cycle 3.
  - `req_ready[0,1,3]` stay 0 throughout.
- **Round-robin:** all four `req_valid` held at 1 from reset, each with a distinct instruction.
  - Accepts in cycles 0, 4, 8, 12, 16 to requesters 0, 1, 2, 3, 0.
  - Each response matches its own requester's operands.
- **Backpressure:** `rsp_ready[1]`=0 for 5 cycles after `rsp_valid[1]` rises, with other requesters valid.
  - `rsp_valid[1]` and `rsp_result` stay stable throughout.
  - No `req_ready` is asserted.
  - The next accept occurs in the cycle after `rsp_ready[1]` rises.
- **Reset mid-WAIT:** assert `reset` in cycle 1 of an operation from requester 3.
  - Next cycle: `busy`=0, `alu_iw`=0, `rsp_result`=0.
  - No `rsp_valid` pulse ever appears for the dropped operation.
  - With all requesters valid, the next grant goes to requester 0.
- **`ALU_LATENCY`=3, ADD 7+8:**
  - Expect `rsp_valid` in cycle 5 with `rsp_result`=15.
  - Minimum issue period is 6 cycles.
